// File: rtl/axi4_mem_responder_if.sv
// AXI4 channel bundle between an FPGA-side master and axi4_mem_responder.
// Master drives requests and write data; slave drives readies and responses.
interface axi4_mem_responder_if #(
   parameter int ADDR_BITS = 32,
   parameter int DATA_BITS = 64,
   parameter int ID_BITS   = 4
);
   logic                   ar_valid;
   logic                   ar_ready;
   logic [ADDR_BITS-1:0]   ar_addr;
   logic [ID_BITS-1:0]     ar_id;
   logic [2:0]             ar_size;
   logic [7:0]             ar_len;

   logic                   aw_valid;
   logic                   aw_ready;
   logic [ADDR_BITS-1:0]   aw_addr;
   logic [ID_BITS-1:0]     aw_id;
   logic [2:0]             aw_size;
   logic [7:0]             aw_len;

   logic                   w_valid;
   logic                   w_ready;
   logic [DATA_BITS/8-1:0] w_strb;
   logic [DATA_BITS-1:0]   w_data;
   logic                   w_last;

   logic                   r_valid;
   logic                   r_ready;
   logic [1:0]             r_resp;
   logic [ID_BITS-1:0]     r_id;
   logic [DATA_BITS-1:0]   r_data;
   logic                   r_last;

   logic                   b_valid;
   logic                   b_ready;
   logic [1:0]             b_resp;
   logic [ID_BITS-1:0]     b_id;

   modport master (
      output ar_valid, ar_addr, ar_id, ar_size, ar_len,
      input  ar_ready,
      output aw_valid, aw_addr, aw_id, aw_size, aw_len,
      input  aw_ready,
      output w_valid, w_strb, w_data, w_last,
      input  w_ready,
      input  r_valid, r_resp, r_id, r_data, r_last,
      output r_ready,
      input  b_valid, b_resp, b_id,
      output b_ready
   );

   modport slave (
      input  ar_valid, ar_addr, ar_id, ar_size, ar_len,
      output ar_ready,
      input  aw_valid, aw_addr, aw_id, aw_size, aw_len,
      output aw_ready,
      input  w_valid, w_strb, w_data, w_last,
      output w_ready,
      output r_valid, r_resp, r_id, r_data, r_last,
      input  r_ready,
      output b_valid, b_resp, b_id,
      input  b_ready
   );
endinterface

// File: rtl/axi4_mem_responder.sv
// AXI4 slave memory: INCR bursts, byte strobes, SLVERR beyond DEPTH_WORDS; one read and one write burst in flight.
// Latency: first R beat the cycle after AR handshake, next beat the cycle after each R handshake; B the cycle after the last W beat.
// Backpressure: R outputs held while r_ready low; with AXI4_MEM_RESP_STALL_EN an LFSR stalls r_valid (before first show) and w_ready.
module axi4_mem_responder #(
   parameter int ADDR_BITS   = 32,
   parameter int DATA_BITS   = 64,
   parameter int ID_BITS     = 4,
   parameter int DEPTH_WORDS = 4096
) (
   input  logic                clock,
   input  logic                reset,
   axi4_mem_responder_if.slave axi
);
   localparam int STRB_BITS = DATA_BITS / 8;
   localparam int LANE_BITS = $clog2(STRB_BITS);
   localparam int IDX_BITS  = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   localparam logic [2:0] MAX_SIZE = 3'(LANE_BITS);
   localparam logic [1:0] OKAY   = 2'b00;
   localparam logic [1:0] SLVERR = 2'b10;

   typedef enum logic {R_IDLE, R_BURST} r_state_t;
   typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;

   logic [DATA_BITS-1:0] mem [DEPTH_WORDS];

   function automatic logic [ADDR_BITS-1:0] next_addr(input logic [ADDR_BITS-1:0] a,
                                                      input logic [2:0] size);
      logic [2:0] sz;
      sz = (size > MAX_SIZE) ? MAX_SIZE : size;
      return a + (ADDR_BITS'(1) << sz);
   endfunction

   function automatic logic in_range(input logic [ADDR_BITS-1:0] a);
      return (a >> LANE_BITS) < ADDR_BITS'(DEPTH_WORDS);
   endfunction

   function automatic logic [IDX_BITS-1:0] word_idx(input logic [ADDR_BITS-1:0] a);
      return IDX_BITS'(a >> LANE_BITS);
   endfunction

   logic stall;
`ifdef AXI4_MEM_RESP_STALL_EN
   logic [15:0] lfsr;
   logic        r_shown;

   always_ff @(posedge clock) begin
      if (!reset) begin
         lfsr    <= 16'hACE1;
         r_shown <= 1'b0;
      end else begin
         lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
         if (axi.r_valid && axi.r_ready) r_shown <= 1'b0;
         else if (axi.r_valid)           r_shown <= 1'b1;
      end
   end
   assign stall = (lfsr[1:0] == 2'b00);
   // A beat already shown must stay valid until accepted.
   wire rd_stall = stall && !r_shown;
`else
   assign stall = 1'b0;
   wire rd_stall = 1'b0;
`endif

   // ---------------- read channel ----------------
   r_state_t             r_state, r_state_nxt;
   logic                 rd_load;
   logic [ADDR_BITS-1:0] rd_load_addr, rd_addr;
   logic [2:0]           rd_size;
   logic [7:0]           rd_left;

   always_ff @(posedge clock) begin
      if (!reset) r_state <= R_IDLE;
      else        r_state <= r_state_nxt;
   end

   always_comb begin
      r_state_nxt  = r_state;
      axi.ar_ready = 1'b0;
      axi.r_valid  = 1'b0;
      rd_load      = 1'b0;
      rd_load_addr = axi.ar_addr;
      case (r_state)
         R_IDLE: begin
            axi.ar_ready = reset;
            if (axi.ar_valid && reset) begin
               r_state_nxt = R_BURST;
               rd_load     = 1'b1;
            end
         end
         R_BURST: begin
            axi.r_valid  = reset && !rd_stall;
            rd_load_addr = next_addr(rd_addr, rd_size);
            if (axi.r_valid && axi.r_ready) begin
               if (rd_left == 8'd0) r_state_nxt = R_IDLE;
               else                 rd_load     = 1'b1;
            end
         end
      endcase
   end

   // Beat data is captured when the beat is loaded, so a same-cycle write lands after it.
   always_ff @(posedge clock) begin
      if (!reset) begin
         rd_addr    <= '0;
         rd_size    <= '0;
         rd_left    <= '0;
         axi.r_id   <= '0;
         axi.r_data <= '0;
         axi.r_resp <= OKAY;
         axi.r_last <= 1'b0;
      end else if (rd_load) begin
         rd_addr    <= rd_load_addr;
         axi.r_data <= in_range(rd_load_addr) ? mem[word_idx(rd_load_addr)] : '0;
         axi.r_resp <= in_range(rd_load_addr) ? OKAY : SLVERR;
         if (r_state == R_IDLE) begin
            rd_size    <= axi.ar_size;
            rd_left    <= axi.ar_len;
            axi.r_id   <= axi.ar_id;
            axi.r_last <= (axi.ar_len == 8'd0);
         end else begin
            rd_left    <= rd_left - 8'd1;
            axi.r_last <= (rd_left == 8'd1);
         end
      end
   end

   // ---------------- write channel ----------------
   w_state_t             w_state, w_state_nxt;
   logic                 aw_fire, w_fire, w_final, w_beat_err;
   logic [ADDR_BITS-1:0] wr_addr;
   logic [2:0]           wr_size;
   logic [7:0]           wr_len, wr_cnt;
   logic                 wr_err;

   assign w_final    = (wr_cnt == wr_len);
   assign w_beat_err = !in_range(wr_addr) || (axi.w_last != w_final);

   always_ff @(posedge clock) begin
      if (!reset) w_state <= W_IDLE;
      else        w_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt  = w_state;
      axi.aw_ready = 1'b0;
      axi.w_ready  = 1'b0;
      axi.b_valid  = 1'b0;
      aw_fire      = 1'b0;
      w_fire       = 1'b0;
      case (w_state)
         W_IDLE: begin
            axi.aw_ready = reset;
            aw_fire      = axi.aw_valid && reset;
            if (aw_fire) w_state_nxt = W_DATA;
         end
         W_DATA: begin
            axi.w_ready = reset && !stall;
            w_fire      = axi.w_valid && axi.w_ready;
            if (w_fire && w_final) w_state_nxt = W_RESP;
         end
         W_RESP: begin
            axi.b_valid = reset;
            if (axi.b_valid && axi.b_ready) w_state_nxt = W_IDLE;
         end
         default: w_state_nxt = W_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         wr_addr    <= '0;
         wr_size    <= '0;
         wr_len     <= '0;
         wr_cnt     <= '0;
         wr_err     <= 1'b0;
         axi.b_id   <= '0;
         axi.b_resp <= OKAY;
      end else if (aw_fire) begin
         wr_addr  <= axi.aw_addr;
         wr_size  <= axi.aw_size;
         wr_len   <= axi.aw_len;
         wr_cnt   <= 8'd0;
         wr_err   <= 1'b0;
         axi.b_id <= axi.aw_id;
      end else if (w_fire) begin
         wr_addr <= next_addr(wr_addr, wr_size);
         wr_cnt  <= wr_cnt + 8'd1;
         wr_err  <= wr_err | w_beat_err;
         if (w_final) axi.b_resp <= (wr_err | w_beat_err) ? SLVERR : OKAY;
      end
   end

   // Backing store is deliberately not reset.
   always_ff @(posedge clock) begin
      if (w_fire && in_range(wr_addr)) begin
         for (int i = 0; i < STRB_BITS; i++) begin
            if (axi.w_strb[i]) mem[word_idx(wr_addr)][i*8 +: 8] <= axi.w_data[i*8 +: 8];
         end
      end
   end
endmodule

// File: doc/axi4_mem_responder.md
AXI4_MEM_RESPONDER -- requirements
Module: axi4_mem_responder

Interface
REQ-001 SHALL provide parameter ADDR_BITS, default 32, AXI address width.
REQ-002 SHALL provide parameter DATA_BITS, default 64, AXI data width (power of two, >=8).
REQ-003 SHALL provide parameter ID_BITS, default 4, AXI ID width.
REQ-004 SHALL provide parameter DEPTH_WORDS, default 4096, backing store size in DATA_BITS words.
REQ-005 SHALL have port clock  in  1  sole clock; all logic on posedge.
REQ-006 SHALL have port reset  in  1  synchronous, active-low reset.
REQ-007 SHALL have AR inputs ar_valid 1, ar_addr ADDR_BITS, ar_id ID_BITS, ar_size 3, ar_len 8; output ar_ready 1.
REQ-008 SHALL have AW inputs aw_valid 1, aw_addr ADDR_BITS, aw_id ID_BITS, aw_size 3, aw_len 8; output aw_ready 1.
REQ-009 SHALL have W inputs w_valid 1, w_strb DATA_BITS/8, w_data DATA_BITS, w_last 1; output w_ready 1.
REQ-010 SHALL have R outputs r_valid 1, r_resp 2, r_id ID_BITS, r_data DATA_BITS, r_last 1; input r_ready 1.
REQ-011 SHALL have B outputs b_valid 1, b_resp 2, b_id ID_BITS; input b_ready 1.

Function
REQ-012 SHALL act as AXI4 slave memory for an FPGA-side master; transfer occurs only on cycle with valid&&ready high.
REQ-013 SHALL run read FSM R_IDLE->R_BURST on AR handshake; ar_ready=1 only in R_IDLE.
REQ-014 SHALL in R_BURST drive r_valid=1 from cycle after AR handshake; beat count = ar_len+1; r_last=1 on final beat; return to R_IDLE on final R handshake.
REQ-015 SHALL hold r_data/r_id/r_resp/r_last stable while r_valid&&!r_ready.
REQ-016 SHALL run write FSM W_IDLE->W_DATA (AW handshake)->W_RESP (W handshake with beat count reaching aw_len+1)->W_IDLE (B handshake); aw_ready=1 only in W_IDLE, w_ready=1 only in W_DATA, b_valid=1 only in W_RESP.
REQ-017 SHALL support INCR bursts only: beat address += 1<<size; size clamped to log2(DATA_BITS/8); word index = addr>>log2(DATA_BITS/8).
REQ-018 SHALL return full word on reads (narrow lanes not masked); SHALL update only bytes with w_strb bit set on writes.
REQ-019 SHALL report resp 2'b00 (OKAY) for in-range beats; word index >= DEPTH_WORDS gives 2'b10 (SLVERR) with r_data=0 and write dropped.
REQ-020 SHALL report b_resp SLVERR if any beat of burst was out of range, else OKAY.
REQ-021 SHALL report w_last mismatch (w_last!=final-beat) as b_resp SLVERR; burst length still governed by aw_len.
REQ-022 SHALL echo ar_id on every R beat and aw_id on B.
REQ-023 SHALL run read and write FSMs concurrently; same-cycle read and write of one word returns pre-write data.
REQ-024 SHALL allow at most one outstanding read and one outstanding write burst.

Reset
REQ-025 SHALL while reset==0 at posedge force both FSMs idle, beat counters 0, ar_ready=aw_ready=w_ready=r_valid=b_valid=0, r_resp=b_resp=0, r_last=0.
REQ-026 SHALL assert ar_ready and aw_ready first cycle after reset deasserts.
REQ-027 SHALL not clear backing store on reset; reset mid-burst abandons burst with no further R/B beats.

Configuration
REQ-028 SHALL, when AXI4_MEM_RESP_STALL_EN defined, run 16-bit Fibonacci LFSR (taps 16,14,13,11, seed 16'hACE1 at reset) advancing every cycle, and deassert r_valid (before first presentation of a beat) and w_ready on cycles where lfsr[1:0]==2'b00.
REQ-029 SHALL, once r_valid asserted for a beat, keep it high until handshake regardless of LFSR.
REQ-030 SHALL, without AXI4_MEM_RESP_STALL_EN, never stall: no LFSR logic present.

Verification
REQ-031 Write addr 0x40 len 3 size 3 data 1..4 strb 0xFF, then read same -> B OKAY id echoed; R beats 1,2,3,4, r_last on 4th only.
REQ-032 Write 0xAABB at 0x0 strb 0x03 over prior 0xFFFF_FFFF_FFFF_FFFF -> readback 0xFFFF_FFFF_FFFF_AABB.
REQ-033 Read addr DEPTH_WORDS*8 len 0 -> single beat r_resp 2'b10, r_data 0; write same -> b_resp 2'b10.
REQ-034 r_ready held low 5 cycles mid-burst -> R outputs stable, no beat lost or duplicated.
REQ-035 reset low during beat 2 of 4-beat read -> next cycle r_valid=0; after release ar_ready=1, no stale beats.
REQ-036 With AXI4_MEM_RESP_STALL_EN, 16-beat write+read -> data correct, r_valid never drops before handshake, at least one w_ready stall cycle.
